writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
// Final pipeline stage; consumes the 60-bit MEM/WB bundle produced by the memory stage's buffer.
// Selects the write-back value (memory data or ALU/address result) and owns the 16x24-bit register file.
// Exposes two read ports with write-through bypass to decode, plus forwarding taps to execute.
// Tracks retired instructions and a sticky HALT flag.
// PARAMETERS
// DATA_W     24  register / datapath width
// NREGS      16  register count (index width 4)
// ZERO_REG   1   1: R0 reads 0 and ignores writes; 0: R0 is an ordinary register
// CNT_W      32  retired-instruction counter width
// PORTS
// clk         in   1    clock, all state updates on rising edge
// rst         in   1    reset, asynchronous, active-high
// en          in   1    stage enable; 0 = stall (no write, no count, no halt capture)
// bufferIn    in   60   MEM/WB bundle, see field map below
// ra1, ra2    in   4    register-file read addresses
// rd1, rd2    out  24   read data (combinational, bypassed)
// wbRc        out  4    destination of bundle currently in stage
// wbData      out  24   selected write-back value of current bundle
// wbRegWrite  out  1    1 when current bundle will write this cycle (forwarding qualifier)
// halted      out  1    sticky HALT flag
// retired     out  32   count of retired non-bubble bundles
// BEHAVIOUR
// - Field map: [59:58] opType, [57:54] opCode, [53] memToReg, [52] regWrite,
//   [51:48] Rc, [47:24] memData, [23:0] aluResult.
// - wbData = memToReg ? memData : aluResult (pure mux, no latency).
// - wbRegWrite = en & regWrite & ~halted & ~(ZERO_REG & Rc==0).
// - Write: on posedge clk with wbRegWrite=1, regs[Rc] <= wbData; visible on read next cycle.
// - Read: rdN = (ZERO_REG & raN==0) ? 0 : (wbRegWrite & raN==Rc) ? wbData : regs[raN].
//   Same-cycle bypass is mandatory; decode must never see stale data for a write in flight.
// - Bubble: bufferIn == 60'h0 is a NOP; no write, no count.
// - HALT: opType==2'b11 & opCode==4'hF. On posedge with en=1, ~halted, HALT present:
//   halted <= 1; the HALT bundle itself writes nothing but is counted as retired.
// - Halted: all later writes and counts suppressed; rd1/rd2 still serve reads; exits only via rst.
// - retired: +1 per posedge with en=1, ~halted, bufferIn != 0; saturates at all-ones, never wraps.
// - Stall (en=0): regs, halted, retired hold; rd ports still read (no bypass, since wbRegWrite=0).
// - Reset (asynchronous, any time incl. mid-write): all regs=0, halted=0, retired=0 immediately;
//   rd1/rd2 return 0 while rst=1; a write coincident with rst deassertion edge is lost only if rst
//   still high at that edge.
// - Simultaneous: HALT bundle cannot also write (regWrite ignored for HALT encoding).
// - Two reads of same address may coincide with a write to it; both ports get bypassed value.
// TESTING
// 1 Write R3: bundle memToReg=0 regWrite=1 Rc=3 alu=24'h00ABCD, en=1 -> next cycle ra1=3 gives 00ABCD; retired=1.
// 2 memToReg=1 memData=24'h123456 alu=24'hFFFFFF Rc=5 -> R5=123456; wbData=123456 same cycle.
// 3 Bypass: R7=000001 stored, bundle writes R7=000009, ra1=ra2=7 same cycle -> rd1=rd2=000009.
// 4 ZERO_REG=1: write R0=24'hAAAAAA -> rd1(ra=0)=0, wbRegWrite=0, retired still +1.
// 5 HALT bundle {2'b11,4'hF,...} then write R2=000042 -> halted=1, R2 stays 0, retired frozen at count incl. HALT.
// 6 en=0 with valid write bundle -> no change; assert rst mid-run with R4=00FFFF -> R4=0, retired=0 asynchronously.

Source files
------------

// File: rtl/writeback_if.sv
// MEM/WB bundle, decode read ports and forwarding taps of the write-back stage.
interface writeback_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned CNT_W  = 32
);
  localparam int unsigned BUS_W = 8 + IDX_W + 2 * DATA_W;

  logic              en;
  logic [BUS_W-1:0]  bufferIn;
  logic [IDX_W-1:0]  ra1;
  logic [IDX_W-1:0]  ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [IDX_W-1:0]  wbRc;
  logic [DATA_W-1:0] wbData;
  logic              wbRegWrite;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  modport master (
    output en, bufferIn, ra1, ra2,
    input  rd1, rd2, wbRc, wbData, wbRegWrite, halted, retired
  );

  modport slave (
    input  en, bufferIn, ra1, ra2,
    output rd1, rd2, wbRc, wbData, wbRegWrite, halted, retired
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: write-back mux, register file with bypassed read ports,
// retired-instruction counter and sticky HALT flag.
module writeback_stage #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned NREGS    = 16,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = 32
) (
  input logic         clk,
  input logic         rst,
  writeback_if.slave  wb
);
  localparam int unsigned IDX_W = $clog2(NREGS);

  typedef struct packed {
    logic [1:0]        opType;
    logic [3:0]        opCode;
    logic              memToReg;
    logic              regWrite;
    logic [IDX_W-1:0]  rc;
    logic [DATA_W-1:0] memData;
    logic [DATA_W-1:0] aluResult;
  } wbBundle_t;

  wbBundle_t         bundle;
  logic [DATA_W-1:0] regs [NREGS];
  logic              haltedQ;
  logic [CNT_W-1:0]  retiredQ;
  logic              isHalt;
  logic              isBubble;
  logic              zeroDst;
  logic              doWrite;
  logic              doRetire;
  logic [DATA_W-1:0] selData;

  assign bundle = wbBundle_t'(wb.bufferIn);

  // Decode of the bundle currently in the stage.
  always_comb begin
    isHalt   = (bundle.opType == 2'b11) && (bundle.opCode == 4'hF);
    isBubble = (wb.bufferIn == '0);
    zeroDst  = ZERO_REG && (bundle.rc == '0);
    selData  = bundle.memToReg ? bundle.memData : bundle.aluResult;
    doWrite  = wb.en && bundle.regWrite && !haltedQ && !isHalt && !zeroDst;
    doRetire = wb.en && !haltedQ && !isBubble;
  end

  // Read ports: a write in flight is forwarded so decode never sees stale data.
  always_comb begin
    wb.rd1 = '0;
    wb.rd2 = '0;
    if (!rst) begin
      if (ZERO_REG && (wb.ra1 == '0))            wb.rd1 = '0;
      else if (doWrite && (wb.ra1 == bundle.rc)) wb.rd1 = selData;
      else                                       wb.rd1 = regs[wb.ra1];
      if (ZERO_REG && (wb.ra2 == '0))            wb.rd2 = '0;
      else if (doWrite && (wb.ra2 == bundle.rc)) wb.rd2 = selData;
      else                                       wb.rd2 = regs[wb.ra2];
    end
  end

  // Register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (doWrite) begin
      regs[bundle.rc] <= selData;
    end
  end

  // Retire counter saturates; HALT is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retiredQ <= '0;
      haltedQ  <= 1'b0;
    end else begin
      if (doRetire && (retiredQ != '1)) retiredQ <= retiredQ + CNT_W'(1);
      if (wb.en && !haltedQ && isHalt)  haltedQ  <= 1'b1;
    end
  end

  assign wb.wbRc       = bundle.rc;
  assign wb.wbData     = selData;
  assign wb.wbRegWrite = doWrite;
  assign wb.halted     = haltedQ;
  assign wb.retired    = retiredQ;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus random bundles against a
// register-file model; a second instance (R0 ordinary, 3-bit counter) covers saturation.
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [59:0] bus;
  logic [3:0]  ra1, ra2;

  always #5 clk = ~clk;

  writeback_if #(.CNT_W(32)) ifA ();
  writeback_if #(.CNT_W(3))  ifB ();

  assign ifA.en = en;  assign ifA.bufferIn = bus;  assign ifA.ra1 = ra1;  assign ifA.ra2 = ra2;
  assign ifB.en = en;  assign ifB.bufferIn = bus;  assign ifB.ra1 = ra1;  assign ifB.ra2 = ra2;

  writeback_stage #(.ZERO_REG(1'b1), .CNT_W(32)) dutA (.clk(clk), .rst(rst), .wb(ifA.slave));
  writeback_stage #(.ZERO_REG(1'b0), .CNT_W(3))  dutB (.clk(clk), .rst(rst), .wb(ifB.slave));

  int checks = 0;
  int errors = 0;

  logic [23:0]     mregs [2][16];
  bit              mhalt [2];
  longint unsigned mret  [2];
  longint unsigned retMax [2] = '{64'hFFFF_FFFF, 64'd7};
  bit              zr     [2] = '{1'b1, 1'b0};
  string           kname  [7] = '{"wbData", "wbRegWrite", "wbRc", "rd1", "rd2", "halted", "retired"};

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [59:0] mk(input logic [1:0] t, input logic [3:0] c, input logic m,
                                     input logic w, input logic [3:0] rc,
                                     input logic [23:0] mem, input logic [23:0] alu);
    return {t, c, m, w, rc, mem, alu};
  endfunction

  function automatic bit bHalt(input logic [59:0] b);
    return (b[59:58] == 2'b11) && (b[57:54] == 4'hF);
  endfunction

  function automatic logic [23:0] bData(input logic [59:0] b);
    return b[53] ? b[47:24] : b[23:0];
  endfunction

  function automatic bit expWe(input int d);
    return en && bus[52] && !mhalt[d] && !bHalt(bus) && !(zr[d] && bus[51:48] == 4'd0);
  endfunction

  function automatic logic [23:0] expRd(input int d, input logic [3:0] ra);
    if (rst)                               return 24'h0;
    if (zr[d] && ra == 4'd0)               return 24'h0;
    if (expWe(d) && ra == bus[51:48])      return bData(bus);
    return mregs[d][ra];
  endfunction

  function automatic logic [63:0] expOut(input int d, input int k);
    case (k)
      0: return 64'(bData(bus));
      1: return 64'(expWe(d));
      2: return 64'(bus[51:48]);
      3: return 64'(expRd(d, ra1));
      4: return 64'(expRd(d, ra2));
      5: return 64'(mhalt[d]);
      default: return mret[d];
    endcase
  endfunction

  function automatic logic [63:0] obsOut(input int d, input int k);
    if (d == 0) begin
      case (k)
        0: return 64'(ifA.wbData);
        1: return 64'(ifA.wbRegWrite);
        2: return 64'(ifA.wbRc);
        3: return 64'(ifA.rd1);
        4: return 64'(ifA.rd2);
        5: return 64'(ifA.halted);
        default: return 64'(ifA.retired);
      endcase
    end
    case (k)
      0: return 64'(ifB.wbData);
      1: return 64'(ifB.wbRegWrite);
      2: return 64'(ifB.wbRc);
      3: return 64'(ifB.rd1);
      4: return 64'(ifB.rd2);
      5: return 64'(ifB.halted);
      default: return 64'(ifB.retired);
    endcase
  endfunction

  task automatic checkAll(input string ph);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 7; k++)
        chk($sformatf("%s_d%0d_%s", ph, d, kname[k]), obsOut(d, k), expOut(d, k));
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 16; r++) mregs[d][r] = 24'h0;
      mhalt[d] = 1'b0;
      mret[d]  = 0;
    end
  endtask

  // Architectural effect of one rising edge on each model.
  task automatic modelEdge();
    bit we, ret;
    if (rst) return;
    for (int d = 0; d < 2; d++) begin
      we  = expWe(d);
      ret = en && !mhalt[d] && (bus != 60'h0);
      if (we) mregs[d][bus[51:48]] = bData(bus);
      if (ret && mret[d] < retMax[d]) mret[d]++;
      if (ret && bHalt(bus)) mhalt[d] = 1'b1;
    end
  endtask

  task automatic step(input logic [59:0] b, input logic e, input logic [3:0] a1, input logic [3:0] a2);
    bus = b; en = e; ra1 = a1; ra2 = a2;
    #2 checkAll("pre");
    @(posedge clk);
    modelEdge();
    #1 checkAll("post");
    @(negedge clk);
  endtask

  function automatic logic [59:0] rndBundle();
    logic [1:0] t;
    logic [3:0] c;
    if ($urandom_range(0, 9) == 0) return 60'h0;
    t = 2'($urandom_range(0, 3));
    c = 4'($urandom_range(0, 15));
    if (t == 2'b11 && c == 4'hF) c = 4'hE;
    return mk(t, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
              4'($urandom_range(0, 15)), 24'($urandom), 24'($urandom));
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; bus = 60'h0; ra1 = 4'd0; ra2 = 4'd0;
    modelReset();
    #3 checkAll("reset");
    @(negedge clk);
    rst = 1'b0;

    // Write R3 from the ALU result.
    step(mk(2'b00, 4'h1, 1'b0, 1'b1, 4'd3, 24'h0, 24'h00ABCD), 1'b1, 4'd0, 4'd0);
    step(60'h0, 1'b1, 4'd3, 4'd0);
    chk("t1_rd1", 64'(ifA.rd1), 64'h00ABCD);
    chk("t1_retired", 64'(ifA.retired), 64'd1);

    // Memory data selected over ALU result.
    bus = mk(2'b01, 4'h2, 1'b1, 1'b1, 4'd5, 24'h123456, 24'hFFFFFF); en = 1'b1;
    #2 chk("t2_wbData", 64'(ifA.wbData), 64'h123456);
    step(bus, 1'b1, 4'd0, 4'd0);
    step(60'h0, 1'b1, 4'd5, 4'd0);
    chk("t2_rd1", 64'(ifA.rd1), 64'h123456);

    // Same-cycle bypass on both ports.
    step(mk(2'b00, 4'h3, 1'b0, 1'b1, 4'd7, 24'h0, 24'h000001), 1'b1, 4'd0, 4'd0);
    bus = mk(2'b00, 4'h3, 1'b0, 1'b1, 4'd7, 24'h0, 24'h000009); ra1 = 4'd7; ra2 = 4'd7;
    #2 chk("t3_rd1", 64'(ifA.rd1), 64'h000009);
    chk("t3_rd2", 64'(ifA.rd2), 64'h000009);
    step(bus, 1'b1, 4'd7, 4'd7);

    // R0 hardwired to zero in A, ordinary in B.
    bus = mk(2'b00, 4'h4, 1'b0, 1'b1, 4'd0, 24'h0, 24'hAAAAAA); ra1 = 4'd0;
    #2 chk("t4_weA", 64'(ifA.wbRegWrite), 64'd0);
    chk("t4_weB", 64'(ifB.wbRegWrite), 64'd1);
    step(bus, 1'b1, 4'd0, 4'd0);
    chk("t4_rd1A", 64'(ifA.rd1), 64'h0);
    chk("t4_rd1B", 64'(ifB.rd1), 64'hAAAAAA);
    chk("t4_retired", 64'(ifA.retired), 64'd5);

    // Stall: nothing changes.
    step(mk(2'b00, 4'h5, 1'b0, 1'b1, 4'd4, 24'h0, 24'hABCDEF), 1'b0, 4'd4, 4'd0);
    chk("t6_stall_rd1", 64'(ifA.rd1), 64'h0);
    chk("t6_stall_retired", 64'(ifA.retired), 64'd5);

    // Random traffic, no HALT.
    for (int i = 0; i < 200; i++)
      step(rndBundle(), 1'($urandom_range(0, 4) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    chk("sat_B_retired", 64'(ifB.retired), 64'd7);

    // Asynchronous reset while a write is pending.
    step(mk(2'b00, 4'h6, 1'b0, 1'b1, 4'd4, 24'h0, 24'h00FFFF), 1'b1, 4'd0, 4'd0);
    bus = mk(2'b00, 4'h6, 1'b0, 1'b1, 4'd4, 24'h0, 24'h111111); en = 1'b1; ra1 = 4'd4; ra2 = 4'd4;
    #3 rst = 1'b1;
    modelReset();
    #1 chk("rst_rd1", 64'(ifA.rd1), 64'h0);
    chk("rst_retired", 64'(ifA.retired), 64'd0);
    checkAll("inrst");
    @(posedge clk);
    modelEdge();
    #1 checkAll("inrst_edge");
    @(negedge clk);
    rst = 1'b0;
    step(60'h0, 1'b1, 4'd4, 4'd0);
    chk("rst_r4", 64'(ifA.rd1), 64'h0);

    // HALT carries regWrite but must not write; later writes suppressed.
    step(mk(2'b11, 4'hF, 1'b0, 1'b1, 4'd2, 24'h0, 24'h000042), 1'b1, 4'd2, 4'd0);
    step(mk(2'b00, 4'h1, 1'b0, 1'b1, 4'd2, 24'h0, 24'h000042), 1'b1, 4'd2, 4'd2);
    chk("t5_halted", 64'(ifA.halted), 64'd1);
    chk("t5_r2", 64'(ifA.rd1), 64'h0);
    chk("t5_retired", 64'(ifA.retired), 64'd1);
    for (int i = 0; i < 40; i++)
      step(rndBundle(), 1'($urandom_range(0, 4) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    chk("t5_retired_frozen", 64'(ifA.retired), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
